// File: rtl/dma_desc_queue.sv
// Descriptor FIFO plus launcher: pops one {src,dst,bytes} job at a time, pulses go, waits for done/error.
// Pop one cycle after a push into an empty queue; go one cycle after the pop. A full queue drops desc_ready_o.
module dma_desc_queue #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 32,
    parameter int BYTES_W = 32,
    parameter int CNT_W   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          desc_valid_i,
    output logic                          desc_ready_o,
    input  logic [ADDR_W-1:0]             desc_src_i,
    input  logic [ADDR_W-1:0]             desc_dst_i,
    input  logic [BYTES_W-1:0]            desc_bytes_i,
    input  logic                          enable_i,
    input  logic                          flush_i,
    input  logic                          err_clear_i,
    output logic                          dma_go_o,
    output logic [2*ADDR_W+BYTES_W-1:0]   dma_desc_o,
    input  logic                          dma_done_i,
    input  logic                          dma_error_i,
    output logic                          busy_o,
    output logic [$clog2(DEPTH):0]        q_count_o,
    output logic                          cmpl_pulse_o,
    output logic [CNT_W-1:0]              done_cnt_o,
    output logic                          error_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int QW = PW + 1;

    typedef struct packed {
        logic [ADDR_W-1:0]  src;
        logic [ADDR_W-1:0]  dst;
        logic [BYTES_W-1:0] bytes;
    } desc_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GO,
        S_ARM,
        S_WAIT,
        S_HALT
    } state_t;

    desc_t           mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [QW-1:0]   count_q;
    logic [QW-1:0]   count_d;

    state_t          state_q;
    desc_t           cur_desc_q;
    logic            go_q;
    logic            busy_q;
    logic            cmpl_q;
    logic [CNT_W-1:0] done_cnt_q;
    logic            error_q;

    desc_t           in_desc;
    desc_t           head;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;

    assign in_desc = '{src: desc_src_i, dst: desc_dst_i, bytes: desc_bytes_i};
    assign head    = mem_q[rd_ptr_q];
    assign full    = (count_q == QW'(DEPTH));
    assign empty   = (count_q == '0);

    // Flush wins over a same-cycle push and blocks the pop, so the queue empties cleanly.
    assign push = desc_valid_i && !full && !flush_i;
    assign pop  = (state_q == S_IDLE) && enable_i && !empty && !flush_i;

    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_d = count_q + QW'(1);
                2'b01:   count_d = count_q - QW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_desc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (flush_i) begin
                rd_ptr_q <= wr_ptr_q;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cur_desc_q <= '0;
            go_q       <= 1'b0;
            busy_q     <= 1'b0;
            cmpl_q     <= 1'b0;
            done_cnt_q <= '0;
            error_q    <= 1'b0;
        end else begin
            go_q   <= 1'b0;
            cmpl_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        cur_desc_q <= head;
                        // Zero-length jobs complete locally without bothering the wrapper.
                        if (head.bytes == '0) begin
                            cmpl_q     <= 1'b1;
                            done_cnt_q <= done_cnt_q + CNT_W'(1);
                        end else begin
                            state_q <= S_GO;
                            go_q    <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_GO: begin
                    state_q <= S_ARM;
                end
                S_ARM: begin
                    // Status is level and sticky from the previous job; wait for it to clear.
                    if (!dma_done_i && !dma_error_i) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (dma_error_i) begin
                        state_q <= S_HALT;
                        error_q <= 1'b1;
                        cmpl_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (dma_done_i) begin
                        state_q    <= S_IDLE;
                        cmpl_q     <= 1'b1;
                        done_cnt_q <= done_cnt_q + CNT_W'(1);
                        busy_q     <= 1'b0;
                    end
                end
                S_HALT: begin
                    if (err_clear_i) begin
                        state_q <= S_IDLE;
                        error_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign desc_ready_o = !full;
    assign dma_go_o     = go_q;
    assign dma_desc_o   = cur_desc_q;
    assign busy_o       = busy_q;
    assign q_count_o    = count_q;
    assign cmpl_pulse_o = cmpl_q;
    assign done_cnt_o   = done_cnt_q;
    assign error_o      = error_q;

endmodule

// File: tb/tb_dma_desc_queue.sv
// Directed bench for dma_desc_queue: each task drives one scenario and checks its own results.
module tb_dma_desc_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        desc_valid_i;
    logic        desc_ready_o;
    logic [31:0] desc_src_i;
    logic [31:0] desc_dst_i;
    logic [31:0] desc_bytes_i;
    logic        enable_i;
    logic        flush_i;
    logic        err_clear_i;
    logic        dma_go_o;
    logic [95:0] dma_desc_o;
    logic        dma_done_i;
    logic        dma_error_i;
    logic        busy_o;
    logic [2:0]  q_count_o;
    logic        cmpl_pulse_o;
    logic [15:0] done_cnt_o;
    logic        error_o;

    int checks = 0;
    int fails  = 0;
    int go_cnt = 0;
    int cmpl_cnt = 0;

    dma_desc_queue #(.DEPTH(4), .ADDR_W(32), .BYTES_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o),
        .desc_src_i(desc_src_i), .desc_dst_i(desc_dst_i), .desc_bytes_i(desc_bytes_i),
        .enable_i(enable_i), .flush_i(flush_i), .err_clear_i(err_clear_i),
        .dma_go_o(dma_go_o), .dma_desc_o(dma_desc_o),
        .dma_done_i(dma_done_i), .dma_error_i(dma_error_i),
        .busy_o(busy_o), .q_count_o(q_count_o), .cmpl_pulse_o(cmpl_pulse_o),
        .done_cnt_o(done_cnt_o), .error_o(error_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dma_go_o)     go_cnt++;
        if (cmpl_pulse_o) cmpl_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_desc(input logic [31:0] s, input logic [31:0] d, input logic [31:0] b);
        desc_src_i   = s;
        desc_dst_i   = d;
        desc_bytes_i = b;
    endtask

    task automatic push1(input logic [31:0] s, input logic [31:0] d, input logic [31:0] b);
        set_desc(s, d, b);
        desc_valid_i = 1'b1;
        tick();
        desc_valid_i = 1'b0;
    endtask

    task automatic wait_go(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (dma_go_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Called in the GO cycle; returns in the cycle where the completion pulse is expected.
    task automatic complete_job();
        tick();
        tick();
        dma_done_i = 1'b1;
        tick();
        dma_done_i = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (desc_ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready: got %0b want 1", desc_ready_o); end
        checks++; if (dma_go_o !== 1'b0) begin fails++; $display("FAIL reset_go: got %0b want 0", dma_go_o); end
        checks++; if (dma_desc_o !== 96'd0) begin fails++; $display("FAIL reset_desc: got %h want 0", dma_desc_o); end
        checks++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b want 0", busy_o); end
        checks++; if (q_count_o !== 3'd0) begin fails++; $display("FAIL reset_qcount: got %0d want 0", q_count_o); end
        checks++; if (cmpl_pulse_o !== 1'b0) begin fails++; $display("FAIL reset_cmpl: got %0b want 0", cmpl_pulse_o); end
        checks++; if (done_cnt_o !== 16'd0) begin fails++; $display("FAIL reset_donecnt: got %0d want 0", done_cnt_o); end
        checks++; if (error_o !== 1'b0) begin fails++; $display("FAIL reset_error: got %0b want 0", error_o); end
    endtask

    task automatic test_single();
        logic [95:0] exp;
        bit stable;
        int cb;
        exp = {32'h1000, 32'h2000, 32'd64};
        cb = cmpl_cnt;
        enable_i = 1'b1;
        push1(32'h1000, 32'h2000, 32'd64);
        checks++; if (q_count_o !== 3'd1) begin fails++; $display("FAIL single_qcount: got %0d want 1", q_count_o); end
        checks++; if (dma_go_o !== 1'b0) begin fails++; $display("FAIL single_go_early: got %0b want 0", dma_go_o); end
        tick();
        checks++; if (dma_go_o !== 1'b1) begin fails++; $display("FAIL single_go_latency: got %0b want 1", dma_go_o); end
        checks++; if (dma_desc_o !== exp) begin fails++; $display("FAIL single_desc: got %h want %h", dma_desc_o, exp); end
        checks++; if (busy_o !== 1'b1) begin fails++; $display("FAIL single_busy: got %0b want 1", busy_o); end
        tick();
        checks++; if (dma_go_o !== 1'b0) begin fails++; $display("FAIL single_go_width: got %0b want 0", dma_go_o); end
        stable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (dma_desc_o !== exp || busy_o !== 1'b1) stable = 1'b0;
        end
        checks++; if (stable !== 1'b1) begin fails++; $display("FAIL single_desc_stable: got %0b want 1", stable); end
        dma_done_i = 1'b1;
        tick();
        dma_done_i = 1'b0;
        checks++; if (cmpl_pulse_o !== 1'b1) begin fails++; $display("FAIL single_cmpl: got %0b want 1", cmpl_pulse_o); end
        checks++; if (done_cnt_o !== 16'd1) begin fails++; $display("FAIL single_donecnt: got %0d want 1", done_cnt_o); end
        checks++; if (busy_o !== 1'b0) begin fails++; $display("FAIL single_idle: got %0b want 0", busy_o); end
        tick();
        checks++; if (cmpl_cnt - cb !== 1) begin fails++; $display("FAIL single_cmpl_count: got %0d want 1", cmpl_cnt - cb); end
    endtask

    task automatic test_fill();
        logic [95:0] exp;
        bit ok;
        int gb;
        enable_i = 1'b0;
        desc_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_desc(32'h100 + i, 32'h200 + i, 32'd16 * (i + 1));
            tick();
        end
        checks++; if (q_count_o !== 3'd4) begin fails++; $display("FAIL fill_qcount: got %0d want 4", q_count_o); end
        checks++; if (desc_ready_o !== 1'b0) begin fails++; $display("FAIL fill_ready: got %0b want 0", desc_ready_o); end
        set_desc(32'hdead, 32'hbeef, 32'd99);
        tick();
        desc_valid_i = 1'b0;
        checks++; if (q_count_o !== 3'd4) begin fails++; $display("FAIL fill_fifth_refused: got %0d want 4", q_count_o); end
        gb = go_cnt;
        enable_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = {32'h100 + 32'(i), 32'h200 + 32'(i), 32'd16 * 32'(i + 1)};
            wait_go(ok);
            checks++; if (ok !== 1'b1) begin fails++; $display("FAIL fill_go_timeout[%0d]: got none want go", i); end
            checks++; if (dma_desc_o !== exp) begin fails++; $display("FAIL fill_order[%0d]: got %h want %h", i, dma_desc_o, exp); end
            complete_job();
            checks++; if (cmpl_pulse_o !== 1'b1) begin fails++; $display("FAIL fill_cmpl[%0d]: got %0b want 1", i, cmpl_pulse_o); end
        end
        tick();
        checks++; if (done_cnt_o !== 16'd5) begin fails++; $display("FAIL fill_donecnt: got %0d want 5", done_cnt_o); end
        checks++; if (go_cnt - gb !== 4) begin fails++; $display("FAIL fill_go_count: got %0d want 4", go_cnt - gb); end
        checks++; if (q_count_o !== 3'd0) begin fails++; $display("FAIL fill_drained: got %0d want 0", q_count_o); end
    endtask

    task automatic test_stale_done();
        bit ok;
        int cb;
        enable_i = 1'b0;
        push1(32'h3000, 32'h4000, 32'd8);
        push1(32'h3100, 32'h4100, 32'd8);
        cb = cmpl_cnt;
        enable_i = 1'b1;
        wait_go(ok);
        checks++; if (ok !== 1'b1) begin fails++; $display("FAIL stale_go1: got none want go"); end
        tick();
        tick();
        dma_done_i = 1'b1;
        tick();
        checks++; if (cmpl_pulse_o !== 1'b1) begin fails++; $display("FAIL stale_cmpl1: got %0b want 1", cmpl_pulse_o); end
        wait_go(ok);
        checks++; if (ok !== 1'b1) begin fails++; $display("FAIL stale_go2: got none want go"); end
        repeat (6) tick();
        checks++; if (busy_o !== 1'b1) begin fails++; $display("FAIL stale_held_in_arm: got %0b want 1", busy_o); end
        checks++; if (done_cnt_o !== 16'd6) begin fails++; $display("FAIL stale_no_spurious: got %0d want 6", done_cnt_o); end
        checks++; if (cmpl_cnt - cb !== 1) begin fails++; $display("FAIL stale_cmpl_count: got %0d want 1", cmpl_cnt - cb); end
        dma_done_i = 1'b0;
        tick();
        dma_done_i = 1'b1;
        tick();
        dma_done_i = 1'b0;
        checks++; if (cmpl_pulse_o !== 1'b1) begin fails++; $display("FAIL stale_cmpl2: got %0b want 1", cmpl_pulse_o); end
        checks++; if (done_cnt_o !== 16'd7) begin fails++; $display("FAIL stale_donecnt: got %0d want 7", done_cnt_o); end
    endtask

    task automatic test_error_halt();
        bit ok;
        int gb;
        logic [95:0] exp3;
        logic [95:0] exp4;
        exp3 = {32'h5300, 32'h6300, 32'd48};
        exp4 = {32'h5400, 32'h6400, 32'd64};
        enable_i = 1'b0;
        push1(32'h5100, 32'h6100, 32'd16);
        push1(32'h5200, 32'h6200, 32'd32);
        push1(32'h5300, 32'h6300, 32'd48);
        enable_i = 1'b1;
        wait_go(ok);
        complete_job();
        wait_go(ok);
        checks++; if (ok !== 1'b1) begin fails++; $display("FAIL err_go2: got none want go"); end
        tick();
        tick();
        dma_error_i = 1'b1;
        dma_done_i  = 1'b1;
        tick();
        dma_error_i = 1'b0;
        dma_done_i  = 1'b0;
        checks++; if (error_o !== 1'b1) begin fails++; $display("FAIL err_flag: got %0b want 1", error_o); end
        checks++; if (cmpl_pulse_o !== 1'b1) begin fails++; $display("FAIL err_cmpl: got %0b want 1", cmpl_pulse_o); end
        checks++; if (done_cnt_o !== 16'd8) begin fails++; $display("FAIL err_donecnt: got %0d want 8", done_cnt_o); end
        gb = go_cnt;
        repeat (8) tick();
        checks++; if (go_cnt !== gb) begin fails++; $display("FAIL err_halt_no_launch: got %0d want %0d", go_cnt, gb); end
        checks++; if (q_count_o !== 3'd1) begin fails++; $display("FAIL err_queue_kept: got %0d want 1", q_count_o); end
        push1(32'h5400, 32'h6400, 32'd64);
        checks++; if (q_count_o !== 3'd2) begin fails++; $display("FAIL err_halt_push: got %0d want 2", q_count_o); end
        err_clear_i = 1'b1;
        tick();
        err_clear_i = 1'b0;
        checks++; if (error_o !== 1'b0) begin fails++; $display("FAIL err_cleared: got %0b want 0", error_o); end
        wait_go(ok);
        checks++; if (dma_desc_o !== exp3) begin fails++; $display("FAIL err_job3: got %h want %h", dma_desc_o, exp3); end
        complete_job();
        wait_go(ok);
        checks++; if (dma_desc_o !== exp4) begin fails++; $display("FAIL err_job4: got %h want %h", dma_desc_o, exp4); end
        complete_job();
        checks++; if (done_cnt_o !== 16'd10) begin fails++; $display("FAIL err_final_donecnt: got %0d want 10", done_cnt_o); end
    endtask

    task automatic test_zero_bytes();
        int gb;
        logic [95:0] exp;
        exp = {32'h7000, 32'h8000, 32'd0};
        tick();
        gb = go_cnt;
        enable_i = 1'b1;
        push1(32'h7000, 32'h8000, 32'd0);
        tick();
        checks++; if (cmpl_pulse_o !== 1'b1) begin fails++; $display("FAIL zero_cmpl: got %0b want 1", cmpl_pulse_o); end
        checks++; if (done_cnt_o !== 16'd11) begin fails++; $display("FAIL zero_donecnt: got %0d want 11", done_cnt_o); end
        checks++; if (busy_o !== 1'b0) begin fails++; $display("FAIL zero_busy: got %0b want 0", busy_o); end
        checks++; if (dma_desc_o !== exp) begin fails++; $display("FAIL zero_desc: got %h want %h", dma_desc_o, exp); end
        repeat (3) tick();
        checks++; if (go_cnt !== gb) begin fails++; $display("FAIL zero_no_go: got %0d want %0d", go_cnt, gb); end
    endtask

    task automatic test_flush();
        bit ok;
        int gb;
        enable_i = 1'b1;
        push1(32'h9000, 32'ha000, 32'd128);
        wait_go(ok);
        checks++; if (ok !== 1'b1) begin fails++; $display("FAIL flush_go: got none want go"); end
        for (int i = 0; i < 3; i++) push1(32'h9100 + i, 32'ha100 + i, 32'd4);
        checks++; if (q_count_o !== 3'd3) begin fails++; $display("FAIL flush_queued: got %0d want 3", q_count_o); end
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        checks++; if (q_count_o !== 3'd0) begin fails++; $display("FAIL flush_empty: got %0d want 0", q_count_o); end
        checks++; if (busy_o !== 1'b1) begin fails++; $display("FAIL flush_job_alive: got %0b want 1", busy_o); end
        set_desc(32'h9900, 32'ha900, 32'd4);
        desc_valid_i = 1'b1;
        flush_i = 1'b1;
        tick();
        desc_valid_i = 1'b0;
        flush_i = 1'b0;
        checks++; if (q_count_o !== 3'd0) begin fails++; $display("FAIL flush_push_dropped: got %0d want 0", q_count_o); end
        complete_job();
        checks++; if (cmpl_pulse_o !== 1'b1) begin fails++; $display("FAIL flush_job_cmpl: got %0b want 1", cmpl_pulse_o); end
        checks++; if (done_cnt_o !== 16'd12) begin fails++; $display("FAIL flush_donecnt: got %0d want 12", done_cnt_o); end
        gb = go_cnt;
        repeat (8) tick();
        checks++; if (go_cnt !== gb) begin fails++; $display("FAIL flush_no_more_go: got %0d want %0d", go_cnt, gb); end
        checks++; if (desc_ready_o !== 1'b1) begin fails++; $display("FAIL flush_ready: got %0b want 1", desc_ready_o); end
    endtask

    initial begin
        rst = 1'b1;
        desc_valid_i = 1'b0;
        desc_src_i = '0;
        desc_dst_i = '0;
        desc_bytes_i = '0;
        enable_i = 1'b0;
        flush_i = 1'b0;
        err_clear_i = 1'b0;
        dma_done_i = 1'b0;
        dma_error_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        test_reset();
        test_single();
        test_fill();
        test_stale_done();
        test_error_halt();
        test_zero_bytes();
        test_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
